// File: rtl/cl_bud_pkg.sv
// rtl/cl_bud_pkg.sv - shared AXI constants and init FSM state type for the bud memory block
package cl_bud_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RST,
    ADDR,
    DATA,
    RESP
  } init_state_t;

endpackage

// File: rtl/cl_bud_mem_init.sv
// rtl/cl_bud_mem_init.sv - post-reset fill of the bud block memory over AXI4 INCR write bursts
module cl_bud_mem_init
  import cl_bud_pkg::*;
#(
  parameter int                    MEM_WORDS = 1024,
  parameter int                    BURST_LEN = 16,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [AXI_ID_W-1:0]   AXI_ID    = 4'h0
) (
  input  logic                    clk,
  input  logic                    sync_rst_n,
  input  logic                    rsta_busy,
  input  logic                    rstb_busy,
  input  logic                    init_start,
  input  logic                    init_mode,
  input  logic [AXI_DATA_W-1:0]   init_pattern,
  output logic                    init_busy,
  output logic                    init_done,
  output logic                    init_err,
  output logic [AXI_ID_W-1:0]     s_axi_awid,
  output logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  output logic [7:0]              s_axi_awlen,
  output logic [2:0]              s_axi_awsize,
  output logic [1:0]              s_axi_awburst,
  output logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  output logic [AXI_DATA_W-1:0]   s_axi_wdata,
  output logic [7:0]              s_axi_wstrb,
  output logic                    s_axi_wlast,
  output logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic [AXI_ID_W-1:0]     s_axi_bid,
  input  logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_bvalid,
  output logic                    s_axi_bready
);

  // Index is one bit wider than needed so the terminal value MEM_WORDS is representable.
  localparam int                 IDX_W     = $clog2(MEM_WORDS) + 1;
  localparam int                 BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [IDX_W-1:0]   IDX_END   = IDX_W'(MEM_WORDS);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  function automatic logic [AXI_ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + (AXI_ADDR_W'(idx) << 3);
  endfunction

  function automatic logic [AXI_DATA_W-1:0] gen_data(input logic mode,
                                                     input logic [AXI_DATA_W-1:0] pat,
                                                     input logic [IDX_W-1:0] idx);
    return mode ? (pat + AXI_DATA_W'(idx)) : pat;
  endfunction

  init_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    mode_q, mode_d;
  logic [AXI_DATA_W-1:0]   pattern_q, pattern_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    awvalid_q, awvalid_d;
  logic [AXI_ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                    wvalid_q, wvalid_d;
  logic                    wlast_q, wlast_d;
  logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    bready_q, bready_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          mode_d    = init_mode;
          pattern_d = init_pattern;
          idx_d     = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = WAIT_RST;
        end
      end

      WAIT_RST: begin
        if (!(rsta_busy || rstb_busy)) begin
          awvalid_d = 1'b1;
          awaddr_d  = word_addr(idx_q);
          state_d   = ADDR;
        end
      end

      ADDR: begin
        if (s_axi_awready) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          wvalid_d  = 1'b1;
          wdata_d   = gen_data(mode_q, pattern_q, idx_q);
          wlast_d   = (BEAT_LAST == BEAT_W'(0));
          state_d   = DATA;
        end
      end

      DATA: begin
        if (s_axi_wready) begin
          idx_d  = idx_q + IDX_W'(1);
          beat_d = beat_q + BEAT_W'(1);
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = RESP;
          end else begin
            wdata_d = gen_data(mode_q, pattern_q, idx_q + IDX_W'(1));
            wlast_d = ((beat_q + BEAT_W'(1)) == BEAT_LAST);
          end
        end
      end

      RESP: begin
        if (s_axi_bvalid) begin
          bready_d = 1'b0;
          // A bad response is only recorded; the fill always runs to completion.
          if ((s_axi_bresp != AXI_RESP_OKAY) || (s_axi_bid != AXI_ID)) begin
            err_d = 1'b1;
          end
          if (idx_q == IDX_END) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            awvalid_d = 1'b1;
            awaddr_d  = word_addr(idx_q);
            state_d   = ADDR;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      mode_q    <= 1'b0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= BASE_ADDR;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
    end
  end

  assign init_busy     = busy_q;
  assign init_done     = done_q;
  assign init_err      = err_q;
  assign s_axi_awid    = AXI_ID;
  assign s_axi_awaddr  = awaddr_q;
  assign s_axi_awlen   = 8'(BURST_LEN - 1);
  assign s_axi_awsize  = AXI_SIZE_8B;
  assign s_axi_awburst = AXI_BURST_INCR;
  assign s_axi_awvalid = awvalid_q;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wstrb   = 8'hFF;
  assign s_axi_wlast   = wlast_q;
  assign s_axi_wvalid  = wvalid_q;
  assign s_axi_bready  = bready_q;

endmodule
